// File: rtl/sfx_sequencer.sv
// sfx_sequencer: buffers sfx {id,dur} requests in a FIFO and plays each for dur ticks on the tone generator.
// Optional urgent preemption is compiled in when SFX_PREEMPT_EN is defined.
module sfx_sequencer #(
  parameter int unsigned ID_W  = 4,
  parameter int unsigned DUR_W = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sfx_valid,
  input  logic [ID_W-1:0]        sfx_id,
  input  logic [DUR_W-1:0]       sfx_dur,
`ifdef SFX_PREEMPT_EN
  input  logic                   sfx_urgent,
`endif
  output logic                   sfx_stall,
  input  logic                   tick,
  output logic                   tone_on,
  output logic [ID_W-1:0]        tone_id,
  output logic                   done_pulse,
  output logic [$clog2(DEPTH):0] queue_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   fifo_id  [DEPTH];
  logic [DUR_W-1:0]  fifo_dur [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [ID_W-1:0]   id_q;
  logic [DUR_W-1:0]  dur_q;
  logic [DUR_W-1:0]  remaining, remaining_nxt;
  logic              tone_on_nxt, done_nxt;
  logic [ID_W-1:0]   tone_id_nxt;
  logic              full, push, pop, urgent;

`ifdef SFX_PREEMPT_EN
  assign urgent = sfx_valid && sfx_urgent;
`else
  assign urgent = 1'b0;
`endif

  // Stall depends only on occupancy, never on a same-cycle pop.
  assign full        = (count == CNT_W'(DEPTH));
  assign push        = sfx_valid && !full && !urgent;
  assign pop         = (state == IDLE) && (count != '0) && !urgent;
  assign sfx_stall   = sfx_valid && full && !urgent;
  assign queue_count = count;

  always_ff @(posedge clock) begin
    if (urgent) begin
      fifo_id[0]  <= sfx_id;
      fifo_dur[0] <= sfx_dur;
    end else if (push) begin
      fifo_id[wr_ptr]  <= sfx_id;
      fifo_dur[wr_ptr] <= sfx_dur;
    end
  end

  // Urgent request replaces the whole queue with itself.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (urgent) begin
      rd_ptr <= '0;
      wr_ptr <= PTR_W'(1);
      count  <= CNT_W'(1);
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      id_q  <= '0;
      dur_q <= '0;
    end else if (pop) begin
      id_q  <= fifo_id[rd_ptr];
      dur_q <= fifo_dur[rd_ptr];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (urgent) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (count != '0) state_nxt = LOAD;
        LOAD:    state_nxt = (dur_q == '0) ? IDLE : PLAY;
        PLAY:    if (tick && remaining == DUR_W'(1)) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    tone_on_nxt   = tone_on;
    tone_id_nxt   = tone_id;
    remaining_nxt = remaining;
    done_nxt      = 1'b0;
    if (urgent) begin
      tone_on_nxt = 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (dur_q == '0) begin
            done_nxt = 1'b1;
          end else begin
            tone_id_nxt   = id_q;
            remaining_nxt = dur_q;
            tone_on_nxt   = 1'b1;
          end
        end
        PLAY: begin
          if (tick) begin
            if (remaining == DUR_W'(1)) begin
              remaining_nxt = '0;
              tone_on_nxt   = 1'b0;
              done_nxt      = 1'b1;
            end else begin
              remaining_nxt = remaining - DUR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tone_on    <= 1'b0;
      tone_id    <= '0;
      done_pulse <= 1'b0;
      remaining  <= '0;
    end else begin
      tone_on    <= tone_on_nxt;
      tone_id    <= tone_id_nxt;
      done_pulse <= done_nxt;
      remaining  <= remaining_nxt;
    end
  end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Self-checking bench for sfx_sequencer against a queue-based reference model.
// Define SFX_PREEMPT_EN for both files to exercise urgent preemption.
module tb_sfx_sequencer;
  localparam int unsigned ID_W  = 4;
  localparam int unsigned DUR_W = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              sfx_valid = 1'b0;
  logic [ID_W-1:0]   sfx_id = '0;
  logic [DUR_W-1:0]  sfx_dur = '0;
  logic              sfx_urgent = 1'b0;
  logic              tick = 1'b0;
  logic              sfx_stall, tone_on, done_pulse;
  logic [ID_W-1:0]   tone_id;
  logic [CW-1:0]     queue_count;

  sfx_sequencer #(.ID_W(ID_W), .DUR_W(DUR_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .sfx_valid(sfx_valid), .sfx_id(sfx_id), .sfx_dur(sfx_dur),
`ifdef SFX_PREEMPT_EN
    .sfx_urgent(sfx_urgent),
`endif
    .sfx_stall(sfx_stall), .tick(tick), .tone_on(tone_on), .tone_id(tone_id),
    .done_pulse(done_pulse), .queue_count(queue_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: waiting queue plus the sound currently in hand.
  typedef struct { logic [ID_W-1:0] id; int dur; } req_t;
  req_t          q[$];
  req_t          m_cur;
  bit            m_ready, m_loading;
  int            m_left;
  logic          m_on, m_done, m_stall, obs_stall;
  logic [ID_W-1:0] m_id;

  task automatic model_reset();
    q.delete();
    m_ready = 1'b1; m_loading = 1'b0; m_left = 0;
    m_on = 1'b0; m_id = '0; m_done = 1'b0; m_stall = 1'b0; obs_stall = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [ID_W-1:0] id, input int dur,
                            input logic t, input logic u);
    req_t r;
    bit   full_pre;
    r.id = id; r.dur = dur;
    full_pre = (q.size() == DEPTH);
    m_done = 1'b0;
    if (v && u) begin
      q.delete();
      q.push_back(r);
      m_ready = 1'b1; m_loading = 1'b0; m_on = 1'b0;
    end else begin
      if (m_ready) begin
        if (q.size() != 0) begin
          m_cur = q.pop_front();
          m_ready = 1'b0; m_loading = 1'b1;
        end
      end else if (m_loading) begin
        m_loading = 1'b0;
        if (m_cur.dur == 0) begin
          m_done = 1'b1; m_ready = 1'b1;
        end else begin
          m_id = m_cur.id; m_left = m_cur.dur; m_on = 1'b1;
        end
      end else if (t) begin
        if (m_left == 1) begin
          m_on = 1'b0; m_done = 1'b1; m_ready = 1'b1;
        end else begin
          m_left--;
        end
      end
      if (v && !full_pre) q.push_back(r);
    end
  endtask

  // One clock cycle: drive on the falling edge, sample stall, advance, let outputs settle.
  task automatic cycle(input logic v, input logic [ID_W-1:0] id, input int dur,
                       input logic t, input logic u);
    @(negedge clock);
    reset = 1'b0; sfx_valid = v; sfx_id = id; sfx_dur = DUR_W'(dur); tick = t; sfx_urgent = u;
    #1;
    obs_stall = sfx_stall;
    m_stall = v && (q.size() == DEPTH) && !u;
    @(posedge clock);
    model_step(v, id, dur, t, u);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; sfx_valid = 1'b0; tick = 1'b0; sfx_urgent = 1'b0;
    @(posedge clock);
    #1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({tone_on, tone_id, done_pulse, queue_count, sfx_stall} !== '0) begin
      n_fail++;
      $display("FAIL reset: got on=%b id=%0d done=%b qc=%0d stall=%b, want all zero",
               tone_on, tone_id, done_pulse, queue_count, sfx_stall);
    end
  endtask

  task automatic test_single();
    int rise = -1;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      cycle(c == 0, 4'd3, 2, (c % 4) == 3, 1'b0);
      if (tone_on === 1'b1 && rise < 0) rise = c + 1;
      n_checks++;
      if ({tone_on, tone_id, done_pulse, queue_count, obs_stall} !==
          {m_on, m_id, m_done, CW'(q.size()), m_stall}) begin
        n_fail++;
        $display("FAIL single c=%0d: got on=%b id=%0d done=%b qc=%0d st=%b want on=%b id=%0d done=%b qc=%0d st=%b",
                 c, tone_on, tone_id, done_pulse, queue_count, obs_stall, m_on, m_id, m_done, q.size(), m_stall);
      end
    end
    n_checks++;
    if (rise != 3) begin
      n_fail++;
      $display("FAIL single_latency: tone_on rose in cycle %0d, want 3", rise);
    end
  endtask

  task automatic test_back_to_back();
    bit pend = 1'b1;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      cycle(1'b1, ID_W'(c + 1), 10, 1'b0, 1'b0);
      n_checks++;
      if ({tone_on, tone_id, done_pulse, queue_count, obs_stall} !==
          {m_on, m_id, m_done, CW'(q.size()), m_stall}) begin
        n_fail++;
        $display("FAIL b2b_fill c=%0d: got on=%b id=%0d done=%b qc=%0d st=%b want on=%b id=%0d done=%b qc=%0d st=%b",
                 c, tone_on, tone_id, done_pulse, queue_count, obs_stall, m_on, m_id, m_done, q.size(), m_stall);
      end
    end
    n_checks++;
    if (obs_stall !== 1'b1 || queue_count !== CW'(4)) begin
      n_fail++;
      $display("FAIL b2b_full: got stall=%b qc=%0d, want stall=1 qc=4", obs_stall, queue_count);
    end
    for (int c = 0; c < 100; c++) begin
      cycle(pend, 4'd6, 10, 1'b1, 1'b0);
      if (pend && !obs_stall) pend = 1'b0;
      n_checks++;
      if ({tone_on, tone_id, done_pulse, queue_count, obs_stall} !==
          {m_on, m_id, m_done, CW'(q.size()), m_stall}) begin
        n_fail++;
        $display("FAIL b2b_drain c=%0d: got on=%b id=%0d done=%b qc=%0d st=%b want on=%b id=%0d done=%b qc=%0d st=%b",
                 c, tone_on, tone_id, done_pulse, queue_count, obs_stall, m_on, m_id, m_done, q.size(), m_stall);
      end
    end
    n_checks++;
    if (pend) begin
      n_fail++;
      $display("FAIL b2b_accept: sixth request still stalled after 100 cycles, want accepted");
    end
  endtask

  task automatic test_zero_dur();
    int dones = 0;
    int done_at = -1;
    bit saw_on = 1'b0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cycle(c == 0, 4'd7, 0, 1'b1, 1'b0);
      if (done_pulse === 1'b1) begin dones++; done_at = c + 1; end
      if (tone_on !== 1'b0) saw_on = 1'b1;
      n_checks++;
      if ({tone_on, tone_id, done_pulse, queue_count, obs_stall} !==
          {m_on, m_id, m_done, CW'(q.size()), m_stall}) begin
        n_fail++;
        $display("FAIL zero_dur c=%0d: got on=%b id=%0d done=%b qc=%0d st=%b want on=%b id=%0d done=%b qc=%0d st=%b",
                 c, tone_on, tone_id, done_pulse, queue_count, obs_stall, m_on, m_id, m_done, q.size(), m_stall);
      end
    end
    n_checks++;
    if (dones != 1 || done_at != 3 || saw_on) begin
      n_fail++;
      $display("FAIL zero_dur_summary: got dones=%0d at cycle %0d tone_seen=%b, want 1 at cycle 3 tone_seen=0",
               dones, done_at, saw_on);
    end
  endtask

  task automatic test_reset_mid_play();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      cycle(c < 3, ID_W'(c + 4), 5, 1'b0, 1'b0);
      n_checks++;
      if ({tone_on, tone_id, done_pulse, queue_count, obs_stall} !==
          {m_on, m_id, m_done, CW'(q.size()), m_stall}) begin
        n_fail++;
        $display("FAIL midplay_fill c=%0d: got on=%b id=%0d done=%b qc=%0d st=%b want on=%b id=%0d done=%b qc=%0d st=%b",
                 c, tone_on, tone_id, done_pulse, queue_count, obs_stall, m_on, m_id, m_done, q.size(), m_stall);
      end
    end
    do_reset();
    n_checks++;
    if (tone_on !== 1'b0 || queue_count !== '0 || done_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL midplay_reset: got on=%b qc=%0d done=%b, want 0 0 0", tone_on, queue_count, done_pulse);
    end
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, '0, 0, 1'b1, 1'b0);
      n_checks++;
      if ({tone_on, done_pulse, queue_count} !== {m_on, m_done, CW'(q.size())}) begin
        n_fail++;
        $display("FAIL midplay_after c=%0d: got on=%b done=%b qc=%0d want on=%b done=%b qc=%0d",
                 c, tone_on, done_pulse, queue_count, m_on, m_done, q.size());
      end
    end
  endtask

  task automatic test_gap();
    logic prev_on = 1'b0;
    int gap = 0;
    int gaps_seen = 0;
    int last_gap = -1;
    logic [ID_W-1:0] ids[$];
    do_reset();
    for (int c = 0; c < 12; c++) begin
      cycle(c < 2, ID_W'(c + 1), 1, 1'b1, 1'b0);
      if (tone_on === 1'b1 && prev_on === 1'b0) begin
        ids.push_back(tone_id);
        if (ids.size() == 2) begin last_gap = gap; gaps_seen++; end
      end
      if (tone_on === 1'b0 && ids.size() == 1) gap++;
      prev_on = tone_on;
      n_checks++;
      if ({tone_on, tone_id, done_pulse, queue_count, obs_stall} !==
          {m_on, m_id, m_done, CW'(q.size()), m_stall}) begin
        n_fail++;
        $display("FAIL gap c=%0d: got on=%b id=%0d done=%b qc=%0d st=%b want on=%b id=%0d done=%b qc=%0d st=%b",
                 c, tone_on, tone_id, done_pulse, queue_count, obs_stall, m_on, m_id, m_done, q.size(), m_stall);
      end
    end
    n_checks++;
    if (ids.size() != 2 || gaps_seen != 1 || last_gap != 2 || ids[0] !== 4'd1 || ids[1] !== 4'd2) begin
      n_fail++;
      $display("FAIL gap_summary: got %0d sounds gap=%0d, want ids 1,2 with gap 2", ids.size(), last_gap);
    end
  endtask

  task automatic test_random();
    logic v, t, u;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      v = ($urandom_range(0, 2) == 0);
      t = ($urandom_range(0, 1) == 1);
`ifdef SFX_PREEMPT_EN
      u = ($urandom_range(0, 19) == 0);
`else
      u = 1'b0;
`endif
      cycle(v, ID_W'($urandom_range(0, 15)), int'($urandom_range(0, 6)), t, u);
      n_checks++;
      if ({tone_on, tone_id, done_pulse, queue_count, obs_stall} !==
          {m_on, m_id, m_done, CW'(q.size()), m_stall}) begin
        n_fail++;
        $display("FAIL random c=%0d: got on=%b id=%0d done=%b qc=%0d st=%b want on=%b id=%0d done=%b qc=%0d st=%b",
                 c, tone_on, tone_id, done_pulse, queue_count, obs_stall, m_on, m_id, m_done, q.size(), m_stall);
      end
    end
  endtask

`ifdef SFX_PREEMPT_EN
  task automatic test_preempt();
    bit bad_id = 1'b0;
    do_reset();
    for (int c = 0; c < 6; c++) cycle(c < 4, (c == 0) ? 4'd5 : ID_W'(c), (c == 0) ? 20 : 3, 1'b0, 1'b0);
    cycle(1'b1, 4'd9, 4, 1'b0, 1'b1);
    n_checks++;
    if (tone_on !== 1'b0 || queue_count !== CW'(1) || done_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL preempt_abort: got on=%b qc=%0d done=%b, want 0 1 0", tone_on, queue_count, done_pulse);
    end
    for (int c = 0; c < 20; c++) begin
      cycle(1'b0, '0, 0, 1'b1, 1'b0);
      if (tone_on === 1'b1 && tone_id !== 4'd9) bad_id = 1'b1;
      n_checks++;
      if ({tone_on, tone_id, done_pulse, queue_count} !== {m_on, m_id, m_done, CW'(q.size())}) begin
        n_fail++;
        $display("FAIL preempt_play c=%0d: got on=%b id=%0d done=%b qc=%0d want on=%b id=%0d done=%b qc=%0d",
                 c, tone_on, tone_id, done_pulse, queue_count, m_on, m_id, m_done, q.size());
      end
    end
    n_checks++;
    if (bad_id) begin
      n_fail++;
      $display("FAIL preempt_ids: got a sound other than 9 after preemption, want only id 9");
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_zero_dur();
    test_reset_mid_play();
    test_gap();
`ifdef SFX_PREEMPT_EN
    test_preempt();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
